// File: rtl/trigger_in_multi.sv
// Multi-channel trigger sampler: synchronise, hysteresis-filter and timestamp each
// channel's first rising edge per frame; publish hit/veto/position at each frame strobe.
module trigger_in_multi #(
    parameter int NCH         = 4,
    parameter int FILTER_LEN  = 4,
    parameter int POS_W       = 4,
    parameter int VETO_FRAMES = 3
) (
    input  logic               clk400,
    input  logic               reset,
    input  logic               frame,
    input  logic [NCH-1:0]     ch_enable,
    input  logic [NCH-1:0]     trigger_in,
    output logic               trg_valid,
    output logic [NCH-1:0]     trg_mask,
    output logic [NCH-1:0]     veto_mask,
    output logic [NCH*POS_W-1:0] trg_pos
);

    localparam int unsigned      NCH_U     = NCH;
    localparam int unsigned      FL_U      = FILTER_LEN;
    localparam int unsigned      ON_THR    = FILTER_LEN - 1;
    localparam logic [POS_W-1:0] POS_MAX   = '1;
    localparam logic [3:0]       VETO_LOAD = 4'(VETO_FRAMES);

    logic [NCH-1:0]        r_s1;
    logic [NCH-1:0]        r_s2;
    logic [NCH-1:0]        r_filt;
    logic [NCH-1:0]        r_filt_d;
    logic [NCH-1:0]        r_hit;
    logic [FILTER_LEN-1:0] r_win     [NCH];
    logic [POS_W-1:0]      r_pos_cap [NCH];
    logic [3:0]            r_veto_cnt[NCH];
    logic [POS_W-1:0]      r_poscnt;

    logic [NCH-1:0] w_filt_nxt;
    logic [NCH-1:0] w_rise;
    logic [NCH-1:0] w_acc;
    logic [NCH-1:0] w_vetoed;

    function automatic int unsigned popcnt(input logic [FILTER_LEN-1:0] v);
        popcnt = 0;
        for (int unsigned j = 0; j < FL_U; j++) begin
            if (v[j]) popcnt++;
        end
    endfunction

    assign w_rise = r_filt & ~r_filt_d;

    // Hysteresis: set near-full, clear only when empty, otherwise hold.
    always_comb begin
        w_filt_nxt = r_filt;
        w_acc      = '0;
        w_vetoed   = '0;
        for (int unsigned c = 0; c < NCH_U; c++) begin
            if (popcnt(r_win[c]) >= ON_THR) begin
                w_filt_nxt[c] = 1'b1;
            end else if (popcnt(r_win[c]) == 0) begin
                w_filt_nxt[c] = 1'b0;
            end
            if (ch_enable[c] && r_hit[c]) begin
                if (r_veto_cnt[c] == '0) begin
                    w_acc[c] = 1'b1;
                end else begin
                    w_vetoed[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk400) begin
        if (reset) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_filt   <= '0;
            r_filt_d <= '0;
            r_hit    <= '0;
            r_poscnt <= '0;
            for (int unsigned c = 0; c < NCH_U; c++) begin
                r_win[c]      <= '0;
                r_pos_cap[c]  <= '0;
                r_veto_cnt[c] <= '0;
            end
        end else begin
            r_s1     <= trigger_in;
            r_s2     <= r_s1;
            r_filt   <= w_filt_nxt;
            r_filt_d <= r_filt;
            if (frame) begin
                r_poscnt <= '0;
            end else if (r_poscnt != POS_MAX) begin
                r_poscnt <= r_poscnt + POS_W'(1);
            end
            for (int unsigned c = 0; c < NCH_U; c++) begin
                r_win[c] <= {r_win[c][FILTER_LEN-2:0], r_s2[c]};
                if (!ch_enable[c]) begin
                    r_hit[c]      <= 1'b0;
                    r_veto_cnt[c] <= '0;
                end else if (frame) begin
                    // A rise coinciding with the strobe opens the new frame at position 0.
                    r_hit[c]     <= w_rise[c];
                    r_pos_cap[c] <= '0;
                    if (w_acc[c]) begin
                        r_veto_cnt[c] <= VETO_LOAD;
                    end else if (r_veto_cnt[c] != '0) begin
                        r_veto_cnt[c] <= r_veto_cnt[c] - 4'd1;
                    end
                end else if (w_rise[c] && !r_hit[c]) begin
                    r_hit[c]     <= 1'b1;
                    r_pos_cap[c] <= r_poscnt;
                end
            end
        end
    end

    always_ff @(posedge clk400) begin
        if (reset) begin
            trg_valid <= 1'b0;
            trg_mask  <= '0;
            veto_mask <= '0;
            trg_pos   <= '0;
        end else begin
            trg_valid <= frame && (|w_acc);
            if (frame) begin
                trg_mask  <= w_acc;
                veto_mask <= w_vetoed;
                for (int unsigned c = 0; c < NCH_U; c++) begin
                    trg_pos[c*POS_W +: POS_W] <= w_acc[c] ? r_pos_cap[c] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_trigger_in_multi.sv
// Bench for trigger_in_multi: directed scenarios plus random traffic, all checked
// against a cycle-history reference model of the trigger rules.
`timescale 1ns/1ps
module tb_trigger_in_multi;

    localparam int NCH  = 4;
    localparam int FL   = 4;
    localparam int PW   = 4;
    localparam int VF   = 3;
    localparam int MAXC = 4096;
    localparam int PMAX = (1 << PW) - 1;

    logic              clk400 = 1'b0;
    logic              reset;
    logic              frame;
    logic [NCH-1:0]    ch_enable;
    logic [NCH-1:0]    trigger_in;
    logic              trg_valid;
    logic [NCH-1:0]    trg_mask;
    logic [NCH-1:0]    veto_mask;
    logic [NCH*PW-1:0] trg_pos;

    int checks   = 0;
    int failures = 0;

    trigger_in_multi #(
        .NCH(NCH), .FILTER_LEN(FL), .POS_W(PW), .VETO_FRAMES(VF)
    ) dut (
        .clk400(clk400), .reset(reset), .frame(frame), .ch_enable(ch_enable),
        .trigger_in(trigger_in), .trg_valid(trg_valid), .trg_mask(trg_mask),
        .veto_mask(veto_mask), .trg_pos(trg_pos)
    );

    always #5 clk400 = ~clk400;

    // Reference model: pin samples and filter state kept as per-edge history.
    logic [NCH-1:0]    m_pin  [MAXC];
    logic [NCH-1:0]    m_filt [MAXC];
    int                n          = 0;
    int                last_rst   = 0;
    int                last_frame = 0;
    int                vcnt [NCH];
    bit                mhit [NCH];
    int                mpos [NCH];
    logic              e_valid = 1'b0;
    logic [NCH-1:0]    e_mask  = '0;
    logic [NCH-1:0]    e_veto  = '0;
    logic [NCH*PW-1:0] e_pos   = '0;

    function automatic bit pin_at(input int m, input int c);
        if (m <= last_rst) return 1'b0;
        return m_pin[m][c];
    endfunction

    function automatic bit filt_at(input int m, input int c);
        if (m <= last_rst) return 1'b0;
        return m_filt[m][c];
    endfunction

    task automatic model_step();
        int pop;
        int p;
        bit rise;
        bit acc;
        bit vet;
        n = n + 1;
        if (n >= MAXC) begin
            $display("FAIL model_budget observed=%0d expected<%0d", n, MAXC);
            $fatal(1);
        end
        m_pin[n]  = trigger_in;
        m_filt[n] = '0;
        if (reset) begin
            last_rst   = n;
            last_frame = n;
            for (int c = 0; c < NCH; c++) begin
                vcnt[c] = 0; mhit[c] = 1'b0; mpos[c] = 0;
            end
            e_valid = 1'b0; e_mask = '0; e_veto = '0; e_pos = '0;
        end else begin
            if (frame) begin
                e_valid = 1'b0; e_mask = '0; e_veto = '0; e_pos = '0;
            end else begin
                e_valid = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                rise = filt_at(n-1, c) && !filt_at(n-2, c);
                pop = 0;
                for (int j = 0; j < FL; j++) if (pin_at(n-3-j, c)) pop++;
                if (pop >= FL-1)   m_filt[n][c] = 1'b1;
                else if (pop == 0) m_filt[n][c] = 1'b0;
                else               m_filt[n][c] = filt_at(n-1, c);

                if (!ch_enable[c]) begin
                    mhit[c] = 1'b0;
                    vcnt[c] = 0;
                end else if (frame) begin
                    acc = 1'b0; vet = 1'b0;
                    if (mhit[c] && vcnt[c] == 0) begin
                        acc = 1'b1; vcnt[c] = VF;
                    end else begin
                        if (mhit[c]) vet = 1'b1;
                        if (vcnt[c] > 0) vcnt[c]--;
                    end
                    e_mask[c] = acc;
                    e_veto[c] = vet;
                    if (acc) begin
                        e_pos[c*PW +: PW] = PW'(mpos[c]);
                        e_valid = 1'b1;
                    end
                    mhit[c] = rise;
                    mpos[c] = 0;
                end else if (rise && !mhit[c]) begin
                    p = n - last_frame - 1;
                    if (p > PMAX) p = PMAX;
                    mhit[c] = 1'b1;
                    mpos[c] = p;
                end
            end
            if (frame) last_frame = n;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit fr);
        frame = fr;
        @(posedge clk400);
        model_step();
        #2;
        chk("trg_valid", 64'(trg_valid), 64'(e_valid));
        chk("trg_mask",  64'(trg_mask),  64'(e_mask));
        chk("veto_mask", 64'(veto_mask), 64'(e_veto));
        chk("trg_pos",   64'(trg_pos),   64'(e_pos));
    endtask

    task automatic run_pat(input int c, input logic [47:0] pat, input int exp_hits, input string tag);
        int hits;
        hits = 0;
        for (int t = 0; t < 48; t++) begin
            trigger_in[c] = pat[t];
            tick(t % 8 == 0);
            if (trg_valid && trg_mask[c]) hits++;
        end
        trigger_in[c] = 1'b0;
        chk(tag, 64'(hits), 64'(exp_hits));
    endtask

    initial begin
        int  pulses;
        bit  bad;
        int  fprob;
        reset = 1'b1; frame = 1'b0; ch_enable = '1; trigger_in = '0;

        // Reset and idle
        pulses = 0;
        for (int t = 0; t < 23; t++) begin
            reset = (t < 3);
            tick(t % 5 == 0);
            if (trg_valid) pulses++;
        end
        chk("idle_pulses", 64'(pulses), 64'd0);
        chk("idle_mask", 64'(trg_mask), 64'd0);
        chk("idle_pos", 64'(trg_pos), 64'd0);

        // Single hit on ch2, first sample on the frame edge
        for (int t = 0; t <= 11; t++) begin
            trigger_in[2] = (t < 10);
            tick(t % 5 == 0);
            if (t == 10) begin
                chk("single_valid", 64'(trg_valid), 64'd1);
                chk("single_mask", 64'(trg_mask), 64'(4'b0100));
                chk("single_pos", 64'(trg_pos[2*PW +: PW]), 64'd0);
            end
            if (t == 11) begin
                chk("single_valid_drop", 64'(trg_valid), 64'd0);
                chk("single_mask_hold", 64'(trg_mask), 64'(4'b0100));
            end
        end
        trigger_in = '0;
        for (int t = 0; t < 10; t++) tick(t % 5 == 0);

        // Noise rejection on ch0
        run_pat(0, 48'h6,   0, "noise_2sample");
        run_pat(0, 48'hE,   1, "noise_3sample");
        run_pat(0, 48'h7DE, 1, "noise_dip");

        // Two channels in one frame, then ch0 re-triggered into veto
        for (int t = 0; t <= 51; t++) begin
            trigger_in[0] = (t < 50) && (t % 10 >= 1) && (t % 10 <= 4);
            trigger_in[3] = (t >= 3) && (t <= 6);
            tick(t % 10 == 0);
            if (t == 10) begin
                chk("multi_mask", 64'(trg_mask), 64'(4'b1001));
                chk("multi_pos0", 64'(trg_pos[0 +: PW]), 64'd6);
                chk("multi_pos3", 64'(trg_pos[3*PW +: PW]), 64'd8);
                chk("multi_posdiff", 64'(trg_pos[3*PW +: PW] - trg_pos[0 +: PW]), 64'd2);
            end
            if (t == 20 || t == 30 || t == 40) begin
                chk("veto_mask_set", 64'(veto_mask), 64'(4'b0001));
                chk("veto_no_accept", 64'(trg_mask), 64'd0);
            end
            if (t == 50) begin
                chk("veto_expired_mask", 64'(trg_mask), 64'(4'b0001));
                chk("veto_expired_veto", 64'(veto_mask), 64'd0);
                chk("veto_expired_valid", 64'(trg_valid), 64'd1);
            end
        end
        trigger_in = '0;
        for (int t = 0; t < 10; t++) tick(t % 10 == 0);

        // Capture landing exactly on the frame edge
        for (int t = 0; t <= 21; t++) begin
            trigger_in[1] = (t >= 4) && (t <= 9);
            tick(t % 10 == 0);
            if (t == 10) chk("edge_not_old_frame", 64'(trg_mask[1]), 64'd0);
            if (t == 20) begin
                chk("edge_new_frame", 64'(trg_mask[1]), 64'd1);
                chk("edge_pos", 64'(trg_pos[1*PW +: PW]), 64'd0);
            end
        end
        trigger_in = '0;

        // Frame strobe withheld: position saturates
        for (int t = 0; t <= 46; t++) begin
            trigger_in[2] = (t >= 30) && (t <= 40);
            tick(t == 0 || t == 45);
            if (t == 45) begin
                chk("sat_mask", 64'(trg_mask[2]), 64'd1);
                chk("sat_pos", 64'(trg_pos[2*PW +: PW]), 64'(PMAX));
            end
        end
        trigger_in = '0;

        // Disabled channel never reports
        ch_enable = 4'b1101;
        bad = 1'b0;
        for (int t = 0; t < 40; t++) begin
            trigger_in = ((t % 10 >= 1) && (t % 10 <= 4)) ? '1 : '0;
            tick(t % 10 == 0);
            if (trg_mask[1] || veto_mask[1]) bad = 1'b1;
        end
        chk("disabled_ch1", 64'(bad), 64'd0);
        ch_enable = '1;
        trigger_in = '0;
        for (int t = 0; t < 10; t++) tick(t % 10 == 0);

        // Reset with a pending hit and an armed veto
        for (int t = 0; t <= 31; t++) begin
            trigger_in[1] = (t < 30) && (t % 10 >= 1) && (t % 10 <= 4);
            reset = (t == 18);
            tick(t % 10 == 0);
            if (t == 10) chk("rst_pre_accept", 64'(trg_mask[1]), 64'd1);
            if (t == 20) begin
                chk("rst_frame_valid", 64'(trg_valid), 64'd0);
                chk("rst_frame_mask", 64'(trg_mask), 64'd0);
                chk("rst_frame_veto", 64'(veto_mask), 64'd0);
            end
            if (t == 30) begin
                chk("rst_next_mask", 64'(trg_mask), 64'(4'b0010));
                chk("rst_next_veto", 64'(veto_mask), 64'd0);
            end
        end
        reset = 1'b0;

        // Random traffic, including back-to-back strobes and enable changes
        fprob = 6;
        for (int t = 0; t < 2000; t++) begin
            if (t % 200 == 0) fprob = $urandom_range(1, 30);
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 4) == 0) trigger_in[c] = ~trigger_in[c];
            if ($urandom_range(0, 99) == 0) ch_enable[$urandom_range(0, NCH-1)] ^= 1'b1;
            reset = ($urandom_range(0, 499) == 0);
            tick($urandom_range(0, fprob) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
